// File: rtl/odo_sbox_small_inv.sv
// ---------------------------------------------------------------------------
// odo_sbox_small_inv
//
// Loadable inverse for the 6-bit Odo small S-box. A forward table arrives as
// 2**WIDTH entries in index order. Each entry fwd[i] = v writes inv[v] = i,
// which builds the inverse table. Once the table is complete, the block serves
// registered inverse lookups through a valid/ready handshake.
//
// Ports:
//   clk        clock; all state changes on its rising edge
//   rst_n      synchronous reset, active low
//   ld_valid   forward-table entry present
//   ld_data    forward value fwd[i] for the current index i
//   ld_ready   entry accepted when ld_valid && ld_ready (1 whenever rst_n=1)
//   in_valid   lookup request
//   in         value to invert
//   in_ready   lookup accepted when in_valid && in_ready
//   out_valid  lookup result valid
//   out        inverse value inv[in]
//   out_ready  consumer takes out when out_valid && out_ready
//   table_ok   inverse table complete and usable
//   perm_err   duplicate forward value seen during the last load
//
// Build option:
//   ODO_SBOX_INV_PERMCHECK_EN  When this macro is defined, a seen-vector tracks
//                              the forward values during each load. A
//                              duplicate value sets perm_err, and the load
//                              ends in ERR. When it is not defined, duplicates
//                              overwrite silently (last writer wins) and every
//                              load ends in READY.
// ---------------------------------------------------------------------------
module odo_sbox_small_inv #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  output logic             ld_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  input  logic             out_ready,
  output logic             table_ok,
  output logic             perm_err
);

  localparam int DEPTH = 1 << WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] idx_q, idx_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;

  // The inverse RAM is not reset. Its contents only mean something in READY.
  logic [WIDTH-1:0] inv_mem [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] mem_wdata;

  logic             ld_fire;
  logic             in_fire;

`ifdef ODO_SBOX_INV_PERMCHECK_EN
  logic [DEPTH-1:0] seen_q, seen_d;
  logic             perm_err_q, perm_err_d;
`endif

  assign ld_ready = rst_n;
  assign ld_fire  = ld_valid && ld_ready;

  // A pending load beat takes priority over a lookup. A lookup is also held
  // off while an untaken result sits in the output register.
  assign in_ready = (state_q == S_READY) && !ld_valid && (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;

  assign table_ok  = (state_q == S_READY);
  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef ODO_SBOX_INV_PERMCHECK_EN
  assign perm_err = perm_err_q;
`else
  assign perm_err = 1'b0;
`endif

  // Load control: state, index counter, and duplicate tracking.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_wdata = idx_q;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
    seen_d     = seen_q;
    perm_err_d = perm_err_q;
`endif
    if (ld_fire) begin
      mem_we = 1'b1;
      if (state_q == S_LOAD) begin
        mem_wdata = idx_q;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
        if (seen_q[ld_data]) begin
          perm_err_d = 1'b1;
        end
        seen_d[ld_data] = 1'b1;
`endif
        if (idx_q == '1) begin
          // The last entry wraps the counter in the same edge as the state change.
          idx_d = '0;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
          state_d = perm_err_d ? S_ERR : S_READY;
`else
          state_d = S_READY;
`endif
        end else begin
          idx_d = idx_q + WIDTH'(1);
        end
      end else begin
        // In IDLE, READY or ERR, an accepted entry is index 0 of a fresh load.
        mem_wdata = '0;
        idx_d     = WIDTH'(1);
        state_d   = S_LOAD;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
        seen_d          = '0;
        seen_d[ld_data] = 1'b1;
        perm_err_d      = 1'b0;
`endif
      end
    end
  end

  // Lookup output register: hold while stalled, clear on a take with no new accept.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_fire) begin
      out_d       = inv_mem[in];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
      seen_q      <= '0;
      perm_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
`ifdef ODO_SBOX_INV_PERMCHECK_EN
      seen_q      <= seen_d;
      perm_err_q  <= perm_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      inv_mem[ld_data] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_odo_sbox_small_inv.sv
module tb_odo_sbox_small_inv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_valid;
  logic [5:0] ld_data;
  logic       ld_ready;
  logic       in_valid;
  logic [5:0] lk_in;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] lk_out;
  logic       out_ready;
  logic       table_ok;
  logic       perm_err;

  always #5 clk = ~clk;

  odo_sbox_small_inv #(.WIDTH(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .in_valid  (in_valid),
    .in        (lk_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (lk_out),
    .out_ready (out_ready),
    .table_ok  (table_ok),
    .perm_err  (perm_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [5:0] x;
    logic [5:0] exp;
  } vec_t;

  logic [5:0] r28 [64];
  logic [5:0] cur_tbl [64];
  logic [5:0] inv_model [64];
  logic       pe_hist [64];
  logic       tok_hist [64];
  logic       ir_beat0;
  logic       ov_beat0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-28 forward table: a scrambled permutation with the known entries placed at their indices.
  task automatic build_r28();
    int cidx[6] = '{0, 1, 2, 36, 62, 63};
    int cval[6] = '{'h29, 'h18, 'h17, 'h00, 'h09, 'h33};
    for (int i = 0; i < 64; i++) r28[i] = 6'((i * 37 + 11) % 64);
    for (int c = 0; c < 6; c++) begin
      for (int j = 0; j < 64; j++) begin
        if (int'(r28[j]) == cval[c]) begin
          r28[j] = r28[cidx[c]];
          r28[cidx[c]] = 6'(cval[c]);
          break;
        end
      end
    end
  endtask

  // Inverse model: the last index that maps to each value wins.
  task automatic build_model();
    for (int i = 0; i < 64; i++) inv_model[cur_tbl[i]] = 6'(i);
  endtask

  // Streams n beats of cur_tbl. Any lookup request already driven is sampled
  // during beat 0 and then dropped. gap_at inserts idle cycles after that beat.
  task automatic load_beats(input int n, input int gap_at);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = cur_tbl[i];
      if (i == 0) begin
        #1;
        ir_beat0 = in_ready;
      end
      step();
      pe_hist[i]  = perm_err;
      tok_hist[i] = table_ok;
      if (i == 0) begin
        in_valid = 1'b0;
        ov_beat0 = out_valid;
      end
      if (i == gap_at) begin
        ld_valid = 1'b0;
        repeat (3) step();
      end
    end
    ld_valid = 1'b0;
  endtask

  task automatic lookup_chk(input logic [5:0] x, input logic [5:0] exp, input string nm);
    in_valid  = 1'b1;
    lk_in     = x;
    out_ready = 1'b1;
    #1;
    chk({nm, " in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, " out_valid"}, out_valid, 1);
    chk(nm, lk_out, exp);
    step();
  endtask

  initial begin
    vec_t       vecs [6];
    logic [5:0] q [$];
    logic [5:0] hs_in [12];
    int         pat [4] = '{1, 0, 0, 1};
    int         sent;
    int         got;
    logic       stalled;
    logic [5:0] held;
    logic [5:0] x;
    logic [5:0] t;
    int         k;

    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; in_valid = 1'b0; lk_in = '0; out_ready = 1'b1;
    build_r28();

    // Reset state
    repeat (3) step();
    chk("rst table_ok", table_ok, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst perm_err", perm_err, 0);
    chk("rst ld_ready", ld_ready, 0);
    chk("rst out", lk_out, 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    lk_in = 6'h05;
    #1;
    chk("idle ld_ready", ld_ready, 1);
    for (int c = 0; c < 3; c++) begin
      chk("idle in_ready", in_ready, 0);
      step();
      chk("idle out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // Round-28 table load with a gap in ld_valid, then the table-driven lookups
    for (int i = 0; i < 64; i++) cur_tbl[i] = r28[i];
    build_model();
    load_beats(64, 10);
    chk("r28 table_ok mid", tok_hist[62], 0);
    chk("r28 table_ok", table_ok, 1);
    chk("r28 perm_err", perm_err, 0);
    vecs[0] = '{6'h29, 6'h00};
    vecs[1] = '{6'h00, 6'h24};
    vecs[2] = '{6'h33, 6'h3F};
    vecs[3] = '{6'h18, 6'h01};
    vecs[4] = '{6'h17, 6'h02};
    vecs[5] = '{6'h09, 6'h3E};
    for (int v = 0; v < 6; v++) lookup_chk(vecs[v].x, vecs[v].exp, $sformatf("vec%0d", v));

    // Sweep: fwd[inv[x]] == x for every x
    for (int xi = 0; xi < 64; xi++) begin
      in_valid = 1'b1; lk_in = 6'(xi); out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("sweep fwd(inv(%0d))", xi), r28[lk_out], xi);
      step();
    end

    // Back-to-back lookups with out_ready pattern 1,0,0,1
    for (int i = 0; i < 12; i++) hs_in[i] = 6'($urandom_range(63));
    sent = 0; got = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
      out_ready = pat[cyc % 4][0];
      in_valid  = (sent < 12);
      lk_in     = hs_in[sent % 12];
      #1;
      if (stalled) begin
        chk("hs hold valid", out_valid, 1);
        chk("hs hold data", lk_out, held);
      end
      if (out_valid && !out_ready) chk("hs stall in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("hs spurious result", 1, 0);
        else begin
          chk("hs data", lk_out, q.pop_front());
          got++;
        end
      end
      stalled = out_valid && !out_ready;
      held    = lk_out;
      if (in_valid && in_ready) begin
        q.push_back(inv_model[lk_in]);
        sent++;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("hs results taken", got, 12);
    chk("hs queue empty", q.size(), 0);
    chk("hs out_valid idle", out_valid, 0);

    // Duplicate: index 5 repeats index 36's value 0x00
    for (int i = 0; i < 64; i++) cur_tbl[i] = r28[i];
    cur_tbl[5] = 6'h00;
    load_beats(64, -1);
    chk("dup perm_err before 36", pe_hist[35], 0);
`ifdef ODO_SBOX_INV_PERMCHECK_EN
    chk("dup perm_err at 36", pe_hist[36], 1);
    chk("dup perm_err end", perm_err, 1);
    chk("dup table_ok", table_ok, 0);
    in_valid = 1'b1; lk_in = 6'h00;
    #1;
    chk("dup in_ready", in_ready, 0);
    step();
    chk("dup out_valid", out_valid, 0);
    in_valid = 1'b0;
`else
    chk("dup perm_err at 36", pe_hist[36], 0);
    chk("dup perm_err end", perm_err, 0);
    chk("dup table_ok", table_ok, 1);
    lookup_chk(6'h00, 6'h24, "dup inv[0]");
`endif

    // Reset after 20 beats, then a full reload
    for (int i = 0; i < 64; i++) cur_tbl[i] = r28[i];
    load_beats(20, -1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst table_ok", table_ok, 0);
    chk("midrst perm_err", perm_err, 0);
    in_valid = 1'b1; lk_in = 6'h29;
    #1;
    chk("midrst in_ready", in_ready, 0);
    in_valid = 1'b0;
    step();
    load_beats(64, -1);
    chk("midrst no early ok", tok_hist[43], 0);
    chk("midrst table_ok", table_ok, 1);
    lookup_chk(6'h33, 6'h3F, "midrst inv[33]");
    lookup_chk(6'h18, 6'h01, "midrst inv[18]");

    // Reload from READY with a lookup in the same cycle, new random permutation
    for (int i = 0; i < 64; i++) cur_tbl[i] = 6'(i);
    for (int i = 63; i > 0; i--) begin
      k = $urandom_range(i);
      t = cur_tbl[i]; cur_tbl[i] = cur_tbl[k]; cur_tbl[k] = t;
    end
    build_model();
    in_valid = 1'b1; lk_in = 6'h00; out_ready = 1'b1;
    load_beats(64, -1);
    chk("reload in_ready refused", ir_beat0, 0);
    chk("reload no result", ov_beat0, 0);
    chk("reload table_ok drop", tok_hist[0], 0);
    chk("reload table_ok", table_ok, 1);
    for (int r = 0; r < 40; r++) begin
      x = 6'($urandom_range(63));
      lookup_chk(x, inv_model[x], $sformatf("rand inv[%0d]", x));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
